// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation controller slice.
// Debounce default exists only when IRRIGATION_DEBOUNCE_EN is defined.
package irrigation_pkg;

`ifdef IRRIGATION_DEBOUNCE_EN
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
`endif
  localparam int unsigned DEF_MIN_RUN_CYCLES  = 8;
  localparam int unsigned DEF_MAX_RUN_CYCLES  = 32;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 6;

  // Bit positions of the sensors in the raw/filtered input vector
  localparam int unsigned NUM_SENSORS       = 5;
  localparam int unsigned SNS_ENABLE        = 0;
  localparam int unsigned SNS_SOIL_DRY      = 1;
  localparam int unsigned SNS_SOIL_VERY_DRY = 2;
  localparam int unsigned SNS_TANK_LOW      = 3;
  localparam int unsigned SNS_TANK_EMPTY    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRIP     = 3'd1,
    ST_SPRINKLE = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  function automatic logic is_run(input state_e s);
    return (s == ST_DRIP) || (s == ST_SPRINKLE);
  endfunction

endpackage

// File: rtl/irrigation_input_filter.sv
// One sensor bit: 2-flop synchronizer followed by an optional debouncer.
// Debouncer built only when IRRIGATION_DEBOUNCE_EN is defined.
module irrigation_input_filter
  import irrigation_pkg::*;
`ifdef IRRIGATION_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filt
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IRRIGATION_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // Accept a new level on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_filt <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_filt = r_filt;
`else
  assign o_filt = r_sync2;
`endif

endmodule

// File: rtl/irrigation_controller.sv
// Watering FSM with run/cooldown timing and tank-empty lockout, fed by filtered sensors.
// Define IRRIGATION_DEBOUNCE_EN to insert the sensor debouncers.
module irrigation_controller
  import irrigation_pkg::*;
#(
`ifdef IRRIGATION_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`endif
  parameter int unsigned MIN_RUN_CYCLES  = DEF_MIN_RUN_CYCLES,
  parameter int unsigned MAX_RUN_CYCLES  = DEF_MAX_RUN_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       soil_dry,
  input  logic       soil_very_dry,
  input  logic       tank_low,
  input  logic       tank_empty,
  output logic       irrigation_on,
  output logic       splinker_on,
  output logic       dripper_on,
  output logic       tank_alarm,
  output logic       timeout_pulse,
  output logic [2:0] state_o
);

  localparam int unsigned RUN_W  = $clog2(MAX_RUN_CYCLES + 1);
  localparam int unsigned COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [RUN_W-1:0]  RUN_MIN_LAST = RUN_W'(MIN_RUN_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX_LAST = RUN_W'(MAX_RUN_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_SAT      = RUN_W'(MAX_RUN_CYCLES);
  localparam logic [COOL_W-1:0] COOL_LAST    = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_SAT     = COOL_W'(COOLDOWN_CYCLES);

  logic [NUM_SENSORS-1:0] w_raw;
  logic [NUM_SENSORS-1:0] w_filt;

  assign w_raw[SNS_ENABLE]        = enable;
  assign w_raw[SNS_SOIL_DRY]      = soil_dry;
  assign w_raw[SNS_SOIL_VERY_DRY] = soil_very_dry;
  assign w_raw[SNS_TANK_LOW]      = tank_low;
  assign w_raw[SNS_TANK_EMPTY]    = tank_empty;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_filt
    irrigation_input_filter
`ifdef IRRIGATION_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (w_raw[g]),
        .o_filt (w_filt[g])
      );
  end

  logic w_en;
  logic w_dry;
  logic w_very_dry;
  logic w_tank_low;
  logic w_tank_empty;

  assign w_en         = w_filt[SNS_ENABLE];
  assign w_dry        = w_filt[SNS_SOIL_DRY];
  assign w_very_dry   = w_filt[SNS_SOIL_VERY_DRY];
  assign w_tank_low   = w_filt[SNS_TANK_LOW];
  assign w_tank_empty = w_filt[SNS_TANK_EMPTY];

  state_e            r_state;
  state_e            w_next_state;
  logic              w_timeout;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [COOL_W-1:0] r_cool_cnt;
  logic              r_irrigation_on;
  logic              r_splinker_on;
  logic              r_dripper_on;
  logic              r_tank_alarm;
  logic              r_timeout_pulse;

  // Next state; exit order in a run: timeout, then !enable, then soil-wet, then downgrade
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    if (w_tank_empty) begin
      w_next_state = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en && w_very_dry && !w_tank_low) begin
            w_next_state = ST_SPRINKLE;
          end else if (w_en && (w_dry || w_very_dry)) begin
            w_next_state = ST_DRIP;
          end
        end
        ST_DRIP, ST_SPRINKLE: begin
          if (r_run_cnt == RUN_MAX_LAST) begin
            w_next_state = ST_COOLDOWN;
            w_timeout    = 1'b1;
          end else if (!w_en) begin
            w_next_state = ST_COOLDOWN;
          end else if ((r_run_cnt >= RUN_MIN_LAST) && !w_dry && !w_very_dry) begin
            w_next_state = ST_COOLDOWN;
          end else if ((r_state == ST_SPRINKLE) && w_tank_low) begin
            w_next_state = ST_DRIP;
          end
        end
        ST_COOLDOWN: begin
          if (r_cool_cnt == COOL_LAST) begin
            w_next_state = ST_IDLE;
          end
        end
        ST_FAULT:    w_next_state = ST_COOLDOWN;
        default:     w_next_state = ST_IDLE;
      endcase
    end
  end

  // State, saturating counters (zero outside their state) and Moore outputs of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_run_cnt       <= '0;
      r_cool_cnt      <= '0;
      r_irrigation_on <= 1'b0;
      r_splinker_on   <= 1'b0;
      r_dripper_on    <= 1'b0;
      r_tank_alarm    <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (!is_run(r_state)) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != RUN_SAT) begin
        r_run_cnt <= r_run_cnt + RUN_W'(1);
      end

      if (r_state != ST_COOLDOWN) begin
        r_cool_cnt <= '0;
      end else if (r_cool_cnt != COOL_SAT) begin
        r_cool_cnt <= r_cool_cnt + COOL_W'(1);
      end

      r_irrigation_on <= is_run(w_next_state);
      r_splinker_on   <= (w_next_state == ST_SPRINKLE);
      r_dripper_on    <= (w_next_state == ST_DRIP);
      r_tank_alarm    <= (w_next_state == ST_FAULT);
      r_timeout_pulse <= w_timeout;
    end
  end

  assign irrigation_on = r_irrigation_on;
  assign splinker_on   = r_splinker_on;
  assign dripper_on    = r_dripper_on;
  assign tank_alarm    = r_tank_alarm;
  assign timeout_pulse = r_timeout_pulse;
  assign state_o       = r_state;

endmodule

// File: tb/tb_irrigation_controller.sv
// Directed self-checking bench for irrigation_controller (default parameters).
// Sensor latency follows IRRIGATION_DEBOUNCE_EN: 7 edges with debounce, 3 without.
module tb_irrigation_controller;

`ifdef IRRIGATION_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int NVEC = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       soil_dry;
  logic       soil_very_dry;
  logic       tank_low;
  logic       tank_empty;
  logic       irrigation_on;
  logic       splinker_on;
  logic       dripper_on;
  logic       tank_alarm;
  logic       timeout_pulse;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irrigation_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .soil_dry      (soil_dry),
    .soil_very_dry (soil_very_dry),
    .tank_low      (tank_low),
    .tank_empty    (tank_empty),
    .irrigation_on (irrigation_on),
    .splinker_on   (splinker_on),
    .dripper_on    (dripper_on),
    .tank_alarm    (tank_alarm),
    .timeout_pulse (timeout_pulse),
    .state_o       (state_o)
  );

  typedef struct {
    logic       en;
    logic       dry;
    logic       vdry;
    logic       tlow;
    logic       tempty;
    int         cyc;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vecs [NVEC];

  // Expected {state_o, irrigation_on, splinker_on, dripper_on, tank_alarm, timeout_pulse}
  function automatic logic [7:0] mk(input logic [2:0] st, input logic to);
    logic spr, drp;
    spr = (st == 3'd2);
    drp = (st == 3'd1);
    return {st, spr | drp, spr, drp, (st == 3'd4), to};
  endfunction

  function automatic vec_t mkv(input logic e, input logic d, input logic v, input logic l,
                               input logic t, input int c, input logic [7:0] x);
    vec_t r;
    r.en = e; r.dry = d; r.vdry = v; r.tlow = l; r.tempty = t; r.cyc = c; r.exp_o = x;
    return r;
  endfunction

  task automatic drive(input logic e, input logic d, input logic v, input logic l, input logic t);
    enable = e; soil_dry = d; soil_very_dry = v; tank_low = l; tank_empty = t;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [7:0] exp_v);
    logic [7:0] got;
    got = {state_o, irrigation_on, splinker_on, dripper_on, tank_alarm, timeout_pulse};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (state/irr/spr/drip/alarm/to)", nm, got, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mkv(0, 0, 0, 0, 0, 1,       mk(3'd0, 1'b0));
    vecs[1]  = mkv(1, 1, 0, 0, 0, LAT,     mk(3'd1, 1'b0));
    vecs[2]  = mkv(1, 1, 0, 0, 0, 10,      mk(3'd1, 1'b0));
    vecs[3]  = mkv(0, 0, 0, 0, 0, LAT,     mk(3'd3, 1'b0));
    vecs[4]  = mkv(0, 0, 0, 0, 0, 5,       mk(3'd3, 1'b0));
    vecs[5]  = mkv(0, 0, 0, 0, 0, 1,       mk(3'd0, 1'b0));
    vecs[6]  = mkv(1, 1, 1, 0, 0, LAT,     mk(3'd2, 1'b0));
    vecs[7]  = mkv(1, 1, 1, 1, 0, LAT,     mk(3'd1, 1'b0));
    vecs[8]  = mkv(1, 1, 1, 1, 1, LAT,     mk(3'd4, 1'b0));
    vecs[9]  = mkv(0, 0, 0, 0, 0, LAT,     mk(3'd3, 1'b0));
    vecs[10] = mkv(0, 0, 0, 0, 0, 6,       mk(3'd0, 1'b0));
    vecs[11] = mkv(1, 0, 1, 1, 0, LAT,     mk(3'd1, 1'b0));
    vecs[12] = mkv(1, 0, 0, 1, 0, LAT,     mk(3'd1, 1'b0));
    vecs[13] = mkv(1, 0, 0, 1, 0, 8 - LAT, mk(3'd3, 1'b0));
    vecs[14] = mkv(0, 0, 0, 0, 0, 6,       mk(3'd0, 1'b0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    step(2);
    check("reset state", mk(3'd0, 1'b0));
    rst_n = 1'b1;
    step(LAT + 2);
    check("idle after reset", mk(3'd0, 1'b0));

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].en, vecs[i].dry, vecs[i].vdry, vecs[i].tlow, vecs[i].tempty);
      step(vecs[i].cyc);
      check($sformatf("vec%0d", i), vecs[i].exp_o);
    end

    // Sprinkle, downgrade without counter restart, then timeout after 32 run cycles
    drive(1, 1, 1, 0, 0);
    step(LAT);
    check("to sprinkle", mk(3'd2, 1'b0));
    drive(1, 1, 1, 1, 0);
    step(LAT);
    check("to downgrade", mk(3'd1, 1'b0));
    step(31 - LAT);
    check("to last run cycle", mk(3'd1, 1'b0));
    drive(0, 0, 0, 0, 0);
    step(1);
    check("to pulse", mk(3'd3, 1'b1));
    step(1);
    check("to pulse end", mk(3'd3, 1'b0));
    step(5);
    check("to idle", mk(3'd0, 1'b0));

    // Tank empty becomes visible on the very edge the timeout would fire
    drive(1, 1, 1, 0, 0);
    step(LAT);
    check("fp sprinkle", mk(3'd2, 1'b0));
    step(32 - LAT);
    drive(1, 1, 1, 0, 1);
    step(LAT - 1);
    check("fp before", mk(3'd2, 1'b0));
    step(1);
    check("fp fault", mk(3'd4, 1'b0));
    drive(0, 0, 0, 0, 0);
    step(LAT);
    check("fp cooldown", mk(3'd3, 1'b0));
    step(6);
    check("fp idle", mk(3'd0, 1'b0));

`ifdef IRRIGATION_DEBOUNCE_EN
    drive(1, 0, 0, 0, 0);
    step(LAT);
    drive(1, 1, 0, 0, 0);
    step(3);
    drive(1, 0, 0, 0, 0);
    step(10);
    check("glitch rejected", mk(3'd0, 1'b0));
    drive(0, 0, 0, 0, 0);
    step(LAT);
`endif

    // Asynchronous reset in the middle of a sprinkler run
    drive(1, 1, 1, 0, 0);
    step(LAT);
    check("pre-reset sprinkle", mk(3'd2, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset", mk(3'd0, 1'b0));
    drive(0, 0, 0, 0, 0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(LAT + 2);
    check("idle after re-release", mk(3'd0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
